// File: rtl/stage2_mem_pkg.sv
// Shared encodings for the stage-2 memory sequencer: op codes, select values,
// FSM states and the decoded control bundle.
package stage2_mem_pkg;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_FETCH   = 3'd1;
   localparam logic [2:0] OP_LOADA   = 3'd2;
   localparam logic [2:0] OP_LOADAB  = 3'd3;
   localparam logic [2:0] OP_PUSHRES = 3'd4;
   localparam logic [2:0] OP_PUSHIMM = 3'd5;
   localparam logic [2:0] OP_CALL    = 3'd6;
   localparam logic [2:0] OP_FETCHA  = 3'd7;

   localparam logic [1:0] DST1_PC    = 2'd0;
   localparam logic [1:0] DST1_MSP   = 2'd1;
   localparam logic [1:0] DST2_MSP   = 2'd0;
   localparam logic [1:0] DST2_RSP   = 2'd1;

   localparam logic [2:0] DATA_PC    = 3'd0;
   localparam logic [2:0] DATA_RES   = 3'd1;
   localparam logic [2:0] DATA_ZEIMM = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_RD_LATCH,
      S_RD2_ADDR,
      S_RD2_WAIT,
      S_RD2_LATCH,
      S_WR
   } seqState_t;

   typedef struct packed {
      logic       Busy;
      logic       Done;
      logic [1:0] MemDst1;
      logic [1:0] MemDst2;
      logic [2:0] MemData;
      logic       MemRead1;
      logic       MemRead2;
      logic       MemWrite1;
      logic       MemWrite2;
      logic       IRWrite;
      logic       ValAWrite;
      logic       ValBWrite;
      logic       MSPStep;
   } memCtl_t;

   function automatic logic isReadOp(input logic [2:0] op);
      return (op == OP_FETCH) || (op == OP_LOADA) || (op == OP_LOADAB) || (op == OP_FETCHA);
   endfunction

   function automatic logic usesPort1(input logic [2:0] op);
      return (op == OP_FETCH) || (op == OP_FETCHA);
   endfunction

   function automatic logic usesPort2Rd(input logic [2:0] op);
      return (op == OP_LOADA) || (op == OP_LOADAB) || (op == OP_FETCHA);
   endfunction

endpackage

// File: rtl/stage2_mem_sequencer_if.sv
// Handshake and memory-control bundle between the main control unit (master)
// and the stage-2 memory sequencer (slave).
interface stage2_mem_sequencer_if;
   logic       Start;
   logic [2:0] Op;
   logic       Busy;
   logic       Done;
   logic [1:0] MemDst1;
   logic [1:0] MemDst2;
   logic [2:0] MemData;
   logic       MemRead1;
   logic       MemRead2;
   logic       MemWrite1;
   logic       MemWrite2;
   logic       IRWrite;
   logic       ValAWrite;
   logic       ValBWrite;
   logic       MSPStep;

   modport master (
      output Start, Op,
      input  Busy, Done, MemDst1, MemDst2, MemData, MemRead1, MemRead2,
             MemWrite1, MemWrite2, IRWrite, ValAWrite, ValBWrite, MSPStep
   );

   modport slave (
      input  Start, Op,
      output Busy, Done, MemDst1, MemDst2, MemData, MemRead1, MemRead2,
             MemWrite1, MemWrite2, IRWrite, ValAWrite, ValBWrite, MSPStep
   );
endinterface

// File: rtl/stage2_mem_decode.sv
// Moore decode of sequencer state and latched op into memory strobes, selects
// and latch enables. Selects depend only on the op, so they hold across a read.
module stage2_mem_decode
   import stage2_mem_pkg::*;
(
   input  seqState_t  State,
   input  logic [2:0] OpR,
   output memCtl_t    Ctl
);

   logic readPhase1;
   logic readPhase2;

   always_comb begin
      Ctl        = '0;
      readPhase1 = (State == S_RD_ADDR) || (State == S_RD_WAIT) || (State == S_RD_LATCH);
      readPhase2 = (State == S_RD2_ADDR) || (State == S_RD2_WAIT) || (State == S_RD2_LATCH);

      Ctl.Busy = (State != S_IDLE);

      if (readPhase1) begin
         if (usesPort1(OpR)) begin
            Ctl.MemRead1 = 1'b1;
            Ctl.MemDst1  = DST1_PC;
         end
         if (usesPort2Rd(OpR)) begin
            Ctl.MemRead2 = 1'b1;
            Ctl.MemDst2  = DST2_MSP;
         end
      end

      if (readPhase2) begin
         Ctl.MemRead2 = 1'b1;
         Ctl.MemDst2  = DST2_MSP;
      end

      case (State)
         S_RD_LATCH: begin
            Ctl.IRWrite   = usesPort1(OpR);
            Ctl.ValAWrite = usesPort2Rd(OpR);
            // LOADAB continues with a second pop; the pointer steps between reads
            if (OpR == OP_LOADAB) Ctl.MSPStep = 1'b1;
            else                  Ctl.Done    = 1'b1;
         end
         S_RD2_LATCH: begin
            Ctl.ValBWrite = 1'b1;
            Ctl.Done      = 1'b1;
         end
         S_WR: begin
            Ctl.Done = 1'b1;
            case (OpR)
               OP_PUSHRES: begin
                  Ctl.MemWrite2 = 1'b1;
                  Ctl.MemDst2   = DST2_MSP;
                  Ctl.MemData   = DATA_RES;
               end
               OP_PUSHIMM: begin
                  Ctl.MemWrite2 = 1'b1;
                  Ctl.MemDst2   = DST2_MSP;
                  Ctl.MemData   = DATA_ZEIMM;
               end
               OP_CALL: begin
                  Ctl.MemWrite2 = 1'b1;
                  Ctl.MemDst2   = DST2_RSP;
                  Ctl.MemData   = DATA_PC;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stage2_mem_sequencer.sv
// Stage-2 memory access sequencer: one operation per Start/Done handshake,
// with an optional fixed read wait between address and latch phases.
//
//   state       | meaning
//   S_IDLE      | waiting for Start; all outputs low
//   S_RD_ADDR   | first read address phase
//   S_RD_WAIT   | first read wait (READ_WAIT cycles)
//   S_RD_LATCH  | first read data latched into IR/ValA
//   S_RD2_ADDR  | second LOADAB read address phase
//   S_RD2_WAIT  | second read wait
//   S_RD2_LATCH | second read data latched into ValB
//   S_WR        | single-cycle write or NOP completion
module stage2_mem_sequencer
   import stage2_mem_pkg::*;
#(
   parameter int READ_WAIT = 0
)(
   input logic                    CLK,
   input logic                    Reset,
   stage2_mem_sequencer_if.slave  bus
);

   localparam logic [1:0] WAIT_LOAD = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

   seqState_t  state;
   seqState_t  stateNext;
   logic [2:0] opR;
   logic [1:0] waitCnt;
   logic       loadWait;
   memCtl_t    ctl;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= S_IDLE;
         opR     <= OP_NOP;
         waitCnt <= 2'd0;
      end else begin
         state <= stateNext;
         if ((state == S_IDLE) && bus.Start) opR <= bus.Op;
         if (loadWait)
            waitCnt <= WAIT_LOAD;
         else if (((state == S_RD_WAIT) || (state == S_RD2_WAIT)) && (waitCnt != 2'd0))
            waitCnt <= waitCnt - 2'd1;
      end
   end

   always_comb begin
      stateNext = state;
      loadWait  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.Start) stateNext = isReadOp(bus.Op) ? S_RD_ADDR : S_WR;
         end
         S_RD_ADDR: begin
            if (READ_WAIT == 0) begin
               stateNext = S_RD_LATCH;
            end else begin
               stateNext = S_RD_WAIT;
               loadWait  = 1'b1;
            end
         end
         S_RD_WAIT: begin
            if (waitCnt == 2'd0) stateNext = S_RD_LATCH;
         end
         S_RD_LATCH: begin
            stateNext = (opR == OP_LOADAB) ? S_RD2_ADDR : S_IDLE;
         end
         S_RD2_ADDR: begin
            if (READ_WAIT == 0) begin
               stateNext = S_RD2_LATCH;
            end else begin
               stateNext = S_RD2_WAIT;
               loadWait  = 1'b1;
            end
         end
         S_RD2_WAIT: begin
            if (waitCnt == 2'd0) stateNext = S_RD2_LATCH;
         end
         S_RD2_LATCH: stateNext = S_IDLE;
         S_WR:        stateNext = S_IDLE;
         default:     stateNext = S_IDLE;
      endcase
   end

   stage2_mem_decode uDecode (
      .State (state),
      .OpR   (opR),
      .Ctl   (ctl)
   );

   assign bus.Busy      = ctl.Busy;
   assign bus.Done      = ctl.Done;
   assign bus.MemDst1   = ctl.MemDst1;
   assign bus.MemDst2   = ctl.MemDst2;
   assign bus.MemData   = ctl.MemData;
   assign bus.MemRead1  = ctl.MemRead1;
   assign bus.MemRead2  = ctl.MemRead2;
   assign bus.MemWrite1 = ctl.MemWrite1;
   assign bus.MemWrite2 = ctl.MemWrite2;
   assign bus.IRWrite   = ctl.IRWrite;
   assign bus.ValAWrite = ctl.ValAWrite;
   assign bus.ValBWrite = ctl.ValBWrite;
   assign bus.MSPStep   = ctl.MSPStep;

endmodule

// File: tb/tb_stage2_mem_sequencer.sv
// Directed bench: cycle table against a READ_WAIT=0 instance, then hand sequences
// against a READ_WAIT=2 instance for wait timing, latency and reset mid-wait.
module tb_stage2_mem_sequencer;

   // Output word layout: {Busy,Done,MemDst1[1:0],MemDst2[1:0],MemData[2:0],
   //   MemRead1,MemRead2,MemWrite1,MemWrite2,IRWrite,ValAWrite,ValBWrite,MSPStep}
   localparam logic [16:0] F_B     = 17'h1_0000;
   localparam logic [16:0] F_DN    = 17'h0_8000;
   localparam logic [16:0] F_D2RSP = 17'h0_0800;
   localparam logic [16:0] F_MDRES = 17'h0_0100;
   localparam logic [16:0] F_MDZE  = 17'h0_0200;
   localparam logic [16:0] F_R1    = 17'h0_0080;
   localparam logic [16:0] F_R2    = 17'h0_0040;
   localparam logic [16:0] F_W2    = 17'h0_0010;
   localparam logic [16:0] F_IR    = 17'h0_0008;
   localparam logic [16:0] F_VA    = 17'h0_0004;
   localparam logic [16:0] F_VB    = 17'h0_0002;
   localparam logic [16:0] F_ST    = 17'h0_0001;
   localparam logic [16:0] F_ZERO  = 17'h0_0000;

   typedef struct {
      logic        rst;
      logic        start;
      logic [2:0]  op;
      logic [16:0] exp;
      string       name;
   } vec_t;

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   int   nVec = 0;
   int   nMis = 0;
   vec_t vecs[$];

   stage2_mem_sequencer_if if0 ();
   stage2_mem_sequencer_if if1 ();

   stage2_mem_sequencer #(.READ_WAIT(0)) dut0 (.CLK(CLK), .Reset(Reset), .bus(if0));
   stage2_mem_sequencer #(.READ_WAIT(2)) dut1 (.CLK(CLK), .Reset(Reset), .bus(if1));

   always #5 CLK = ~CLK;

   logic [16:0] act0, act1;
   assign act0 = {if0.Busy, if0.Done, if0.MemDst1, if0.MemDst2, if0.MemData, if0.MemRead1,
                  if0.MemRead2, if0.MemWrite1, if0.MemWrite2, if0.IRWrite, if0.ValAWrite,
                  if0.ValBWrite, if0.MSPStep};
   assign act1 = {if1.Busy, if1.Done, if1.MemDst1, if1.MemDst2, if1.MemData, if1.MemRead1,
                  if1.MemRead2, if1.MemWrite1, if1.MemWrite2, if1.IRWrite, if1.ValAWrite,
                  if1.ValBWrite, if1.MSPStep};

   task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %05h expected %05h", name, act, exp);
      end
   endtask

   task automatic chkInt(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nMis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic addv(input logic r, input logic s, input logic [2:0] op,
                       input logic [16:0] e, input string n);
      vec_t v;
      v.rst = r; v.start = s; v.op = op; v.exp = e; v.name = n;
      vecs.push_back(v);
   endtask

   task automatic cyc1(input logic s, input logic [2:0] op);
      @(negedge CLK);
      if1.Start = s;
      if1.Op    = op;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, dones, selViol, cycles;
      logic [1:0] prevDst2;
      logic       prevRd;
      logic [2:0] ops[4];
      int         lats[4];

      if0.Start = 1'b0; if0.Op = 3'd0;
      if1.Start = 1'b0; if1.Op = 3'd0;

      // Each row: inputs applied before an edge, outputs expected just after it
      addv(1, 0, 0, F_ZERO,                       "reset0");
      addv(1, 0, 0, F_ZERO,                       "reset1");
      addv(0, 0, 0, F_ZERO,                       "idle");
      addv(0, 1, 1, F_B|F_R1,                     "fetch_addr");
      addv(0, 0, 0, F_B|F_R1|F_IR|F_DN,           "fetch_latch");
      addv(0, 0, 0, F_ZERO,                       "fetch_idle");
      addv(0, 1, 3, F_B|F_R2,                     "loadab_addr");
      addv(0, 0, 0, F_B|F_R2|F_VA|F_ST,           "loadab_latchA");
      addv(0, 0, 0, F_B|F_R2,                     "loadab_addr2");
      addv(0, 0, 0, F_B|F_R2|F_VB|F_DN,           "loadab_latchB");
      addv(0, 0, 0, F_ZERO,                       "loadab_idle");
      addv(0, 1, 6, F_B|F_DN|F_W2|F_D2RSP,        "call_wr");
      addv(0, 1, 5, F_ZERO,                       "start_in_done_ignored");
      addv(0, 1, 5, F_B|F_DN|F_W2|F_MDZE,         "pushimm_wr");
      addv(0, 0, 0, F_ZERO,                       "pushimm_idle");
      addv(0, 1, 4, F_B|F_DN|F_W2|F_MDRES,        "pushres_wr");
      addv(0, 0, 0, F_ZERO,                       "pushres_idle");
      addv(0, 1, 0, F_B|F_DN,                     "nop_wr");
      addv(0, 0, 0, F_ZERO,                       "nop_idle");
      addv(0, 1, 3, F_B|F_R2,                     "busy_addr");
      addv(0, 1, 4, F_B|F_R2|F_VA|F_ST,           "busy_ignore1");
      addv(0, 1, 4, F_B|F_R2,                     "busy_ignore2");
      addv(0, 1, 4, F_B|F_R2|F_VB|F_DN,           "busy_ignore3");
      addv(0, 1, 4, F_ZERO,                       "busy_ignore_done");
      addv(0, 1, 4, F_B|F_DN|F_W2|F_MDRES,        "after_done_accept");
      addv(0, 0, 0, F_ZERO,                       "after_done_idle");
      addv(0, 1, 7, F_B|F_R1|F_R2,                "fetcha_addr");
      addv(0, 0, 0, F_B|F_R1|F_R2|F_IR|F_VA|F_DN, "fetcha_latch");
      addv(0, 0, 0, F_ZERO,                       "fetcha_idle");
      addv(0, 1, 2, F_B|F_R2,                     "loada_addr");
      addv(0, 0, 0, F_B|F_R2|F_VA|F_DN,           "loada_latch");
      addv(0, 0, 0, F_ZERO,                       "loada_idle");
      addv(0, 1, 3, F_B|F_R2,                     "rstmid_addr");
      addv(0, 0, 0, F_B|F_R2|F_VA|F_ST,           "rstmid_latchA");
      addv(0, 0, 0, F_B|F_R2,                     "rstmid_addr2");
      addv(1, 0, 0, F_ZERO,                       "rstmid_reset");
      addv(0, 0, 0, F_ZERO,                       "rstmid_after");
      addv(1, 1, 1, F_ZERO,                       "rst_start_same");
      addv(0, 0, 0, F_ZERO,                       "rst_start_dropped");

      foreach (vecs[i]) begin
         @(negedge CLK);
         Reset     = vecs[i].rst;
         if0.Start = vecs[i].start;
         if0.Op    = vecs[i].op;
         @(posedge CLK);
         #1;
         chk(vecs[i].name, act0, vecs[i].exp);
      end
      @(negedge CLK);
      Reset = 1'b0; if0.Start = 1'b0; if0.Op = 3'd0;

      // READ_WAIT=2 single read, cycle by cycle
      cyc1(1, 3'd2); chk("w2_addr",  act1, F_B|F_R2);
      cyc1(0, 3'd0); chk("w2_wait1", act1, F_B|F_R2);
      cyc1(0, 3'd0); chk("w2_wait2", act1, F_B|F_R2);
      cyc1(0, 3'd0); chk("w2_latch", act1, F_B|F_R2|F_VA|F_DN);
      cyc1(0, 3'd0); chk("w2_idle",  act1, F_ZERO);

      // Start->Done latency, single Done pulse, selects stable while reading
      ops[0] = 3'd1; lats[0] = 4;
      ops[1] = 3'd3; lats[1] = 8;
      ops[2] = 3'd7; lats[2] = 4;
      ops[3] = 3'd5; lats[3] = 1;
      for (int k = 0; k < 4; k++) begin
         lat = 0; dones = 0; selViol = 0; prevRd = 1'b0; prevDst2 = 2'd0;
         cyc1(1, ops[k]);
         cycles = 1;
         for (int c = 0; c < 12; c++) begin
            if (if1.Done) begin
               dones++;
               if (lat == 0) lat = cycles;
            end
            if (prevRd && if1.MemRead2 && (if1.MemDst2 != prevDst2)) selViol++;
            if ((if1.MemRead2 && if1.MemWrite2) || (if1.MemRead1 && if1.MemWrite1)) selViol++;
            prevRd   = if1.MemRead2;
            prevDst2 = if1.MemDst2;
            cyc1(0, 3'd0);
            cycles++;
         end
         chkInt($sformatf("w2_latency_op%0d", ops[k]), lat, lats[k]);
         chkInt($sformatf("w2_done_pulses_op%0d", ops[k]), dones, 1);
         chkInt($sformatf("w2_sel_stable_op%0d", ops[k]), selViol, 0);
      end

      // Reset during the first wait of a LOADAB
      cyc1(1, 3'd3); chk("w2_rst_addr", act1, F_B|F_R2);
      cyc1(0, 3'd0); chk("w2_rst_wait", act1, F_B|F_R2);
      @(negedge CLK);
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      chk("w2_rst_cleared", act1, F_ZERO);
      @(negedge CLK);
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      chk("w2_rst_stays_idle", act1, F_ZERO);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
